xadc_scan_sched: RTL and testbench

Scheduler that sequences the XADC single-channel read engine (start/ch_sel/done/result handshake) over channel ranges and shares it between two requesters: a host (UDP config path) request and a periodic on-board monitor scan.
- Per channel: issues 2^k conversions, averages them, and emits one result word.
- Detects a hung read engine with a timeout and recovers it.
- Sits between the config/readout logic and the XADC read engine, in the clk200 domain.

---
 rtl/xadc_sched_pkg.sv | 20 ++
 rtl/xadc_mon_timer.sv | 39 +++
 rtl/xadc_scan_sched.sv | 209 ++++++++++++++++++++
 tb/tb_xadc_scan_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_sched_pkg.sv
// Shared types and constants for the XADC scan scheduler.
package xadc_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        ACCUM,
        GAP,
        EMIT,
        RECOVER
    } state_t;

    localparam logic SRC_HOST     = 1'b0;
    localparam logic SRC_MON      = 1'b1;
    localparam int   CH_W         = 5;
    localparam int   XADC_RES_W   = 12;
    localparam int   XADC_RST_CYC = 4;

endpackage

// File: rtl/xadc_mon_timer.sv
// Periodic monitor-scan request: counts while enabled, latches a pending flag
// at each period boundary until the scheduler accepts the scan.
module xadc_mon_timer #(
    parameter int MON_PERIOD = 2000000
) (
    input  logic clk200,
    input  logic rst,
    input  logic mon_en,
    input  logic clear,
    output logic mon_pending
);

    localparam int CNT_W = (MON_PERIOD > 2) ? $clog2(MON_PERIOD) : 1;

    logic [CNT_W-1:0] count;
    logic             expire;

    assign expire = mon_en && (count == CNT_W'(MON_PERIOD - 1));

    always_ff @(posedge clk200 or posedge rst) begin
        if (rst) begin
            count       <= '0;
            mon_pending <= 1'b0;
        end else begin
            if (!mon_en || expire) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            // A period ending in the same cycle as an accept re-arms the request.
            if (expire) begin
                mon_pending <= 1'b1;
            end else if (clear) begin
                mon_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/xadc_scan_sched.sv
// Scans channel ranges through the XADC read engine for host and monitor
// requesters, averaging 2^avg samples per channel and recovering hung reads.
module xadc_scan_sched
    import xadc_sched_pkg::*;
#(
    parameter int         MAX_AVG_LOG2 = 4,
    parameter int         TIMEOUT_CYC  = 65535,
    parameter int         GAP_CYC      = 16,
    parameter int         MON_PERIOD   = 2000000,
    parameter logic [4:0] MON_FIRST    = 5'h10,
    parameter logic [4:0] MON_LAST     = 5'h17,
    parameter int         MON_AVG_LOG2 = 2
) (
    input  logic                  clk200,
    input  logic                  rst,
    // host_req is a level held until the one-cycle host_ack; fields are
    // sampled in the cycle the request is accepted.
    input  logic                  host_req,
    input  logic [CH_W-1:0]       host_ch_first,
    input  logic [CH_W-1:0]       host_ch_last,
    input  logic [2:0]            host_avg_log2,
    output logic                  host_ack,
    input  logic                  mon_en,
    output logic                  xadc_start,
    output logic [CH_W-1:0]       xadc_ch_sel,
    input  logic                  xadc_done,
    input  logic [XADC_RES_W-1:0] xadc_result,
    output logic                  xadc_rst,
    output logic                  res_valid,
    output logic [CH_W-1:0]       res_ch,
    output logic [XADC_RES_W-1:0] res_data,
    output logic                  res_src,
    output logic                  res_last,
    output logic                  res_err,
    output logic                  busy
);

    localparam int ACC_W = XADC_RES_W + MAX_AVG_LOG2;
    localparam int CNT_W = MAX_AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int RST_W = $clog2(XADC_RST_CYC);

    state_t                state;
    logic [CH_W-1:0]       ch;
    logic [CH_W-1:0]       last;
    logic [2:0]            avg;
    logic                  src;
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      cnt;
    logic [XADC_RES_W-1:0] sample;
    logic [TMO_W-1:0]      tmo;
    logic [GAP_W-1:0]      gcnt;
    logic [RST_W-1:0]      rcnt;
    logic                  mon_pending;
    logic                  mon_clr;
    logic [2:0]            host_avg_clamped;
    logic [ACC_W-1:0]      acc_sum;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      sample_goal;

    assign busy        = (state != IDLE);
    assign mon_clr     = (state == IDLE) && !host_req && mon_pending;
    assign acc_sum     = acc + ACC_W'(sample);
    assign cnt_inc     = cnt + 1'b1;
    assign sample_goal = CNT_W'(1) << avg;

    always_comb begin
        host_avg_clamped = host_avg_log2;
        if (host_avg_log2 > 3'(MAX_AVG_LOG2)) begin
            host_avg_clamped = 3'(MAX_AVG_LOG2);
        end
    end

    xadc_mon_timer #(
        .MON_PERIOD (MON_PERIOD)
    ) u_mon_timer (
        .clk200      (clk200),
        .rst         (rst),
        .mon_en      (mon_en),
        .clear       (mon_clr),
        .mon_pending (mon_pending)
    );

    always_ff @(posedge clk200 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= '0;
            last        <= '0;
            avg         <= '0;
            src         <= SRC_HOST;
            acc         <= '0;
            cnt         <= '0;
            sample      <= '0;
            tmo         <= '0;
            gcnt        <= '0;
            rcnt        <= '0;
            host_ack    <= 1'b0;
            xadc_start  <= 1'b0;
            xadc_ch_sel <= '0;
            xadc_rst    <= 1'b0;
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_data    <= '0;
            res_src     <= 1'b0;
            res_last    <= 1'b0;
            res_err     <= 1'b0;
        end else begin
            host_ack   <= 1'b0;
            xadc_start <= 1'b0;
            res_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        host_ack <= 1'b1;
                        ch       <= host_ch_first;
                        last     <= host_ch_last;
                        avg      <= host_avg_clamped;
                        src      <= SRC_HOST;
                        state    <= START;
                    end else if (mon_pending) begin
                        ch    <= MON_FIRST;
                        last  <= MON_LAST;
                        avg   <= 3'(MON_AVG_LOG2);
                        src   <= SRC_MON;
                        state <= START;
                    end
                end
                START: begin
                    xadc_start  <= 1'b1;
                    xadc_ch_sel <= ch;
                    tmo         <= '0;
                    state       <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (xadc_done) begin
                        sample <= xadc_result;
                        state  <= ACCUM;
                    end else if (tmo == TMO_W'(TIMEOUT_CYC)) begin
                        xadc_rst <= 1'b1;
                        rcnt     <= '0;
                        state    <= RECOVER;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    cnt <= cnt_inc;
                    // The result is registered here so the strobe lands in EMIT.
                    if (cnt_inc == sample_goal) begin
                        res_valid <= 1'b1;
                        res_data  <= XADC_RES_W'(acc_sum >> avg);
                        res_ch    <= ch;
                        res_src   <= src;
                        res_last  <= (ch == last);
                        res_err   <= 1'b0;
                        state     <= EMIT;
                    end else begin
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gcnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= START;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                EMIT: begin
                    acc <= '0;
                    cnt <= '0;
                    if (ch == last) begin
                        state <= IDLE;
                    end else begin
                        ch    <= ch + 1'b1;
                        gcnt  <= '0;
                        state <= GAP;
                    end
                end
                RECOVER: begin
                    if (rcnt == RST_W'(XADC_RST_CYC - 1)) begin
                        xadc_rst  <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_ch    <= ch;
                        res_src   <= src;
                        res_last  <= (ch == last);
                        res_err   <= 1'b1;
                        acc       <= '0;
                        cnt       <= '0;
                        if (ch == last) begin
                            state <= IDLE;
                        end else begin
                            ch    <= ch + 1'b1;
                            gcnt  <= '0;
                            state <= GAP;
                        end
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_scan_sched.sv
// Bench for xadc_scan_sched: engine model serving pre-planned samples and a
// scoreboard comparing result words against a per-scan expectation queue.
module tb_xadc_scan_sched;

    localparam int MAX_AVG = 4;
    localparam int TO_CYC  = 300;
    localparam int GAP_C   = 4;
    localparam int MON_P   = 60;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        logic [2:0] avg;
        int         pat;
        bit         hang;
        logic [4:0] hang_ch;
        int         exp_nres;
        int         exp_starts;
    } vec_t;

    logic        clk200 = 1'b0;
    logic        rst;
    logic        host_req;
    logic [4:0]  host_ch_first;
    logic [4:0]  host_ch_last;
    logic [2:0]  host_avg_log2;
    logic        host_ack;
    logic        mon_en;
    logic        xadc_start;
    logic [4:0]  xadc_ch_sel;
    logic        xadc_done;
    logic [11:0] xadc_result;
    logic        xadc_rst;
    logic        res_valid;
    logic [4:0]  res_ch;
    logic [11:0] res_data;
    logic        res_src;
    logic        res_last;
    logic        res_err;
    logic        busy;

    logic [19:0] exp_q[$];
    logic [11:0] smp_q[$];
    logic [4:0]  start_q[$];

    int   total = 0;
    int   bad = 0;
    int   ack_cnt = 0;
    int   n_starts = 0;
    int   res_cnt = 0;
    int   rlen = 0;
    bit   hang_en = 1'b0;
    logic [4:0] hang_ch = 5'h0;
    vec_t tbl[6];

    always #5 clk200 = ~clk200;

    xadc_scan_sched #(
        .MAX_AVG_LOG2 (MAX_AVG),
        .TIMEOUT_CYC  (TO_CYC),
        .GAP_CYC      (GAP_C),
        .MON_PERIOD   (MON_P),
        .MON_FIRST    (5'h10),
        .MON_LAST     (5'h17),
        .MON_AVG_LOG2 (2)
    ) dut (
        .clk200        (clk200),
        .rst           (rst),
        .host_req      (host_req),
        .host_ch_first (host_ch_first),
        .host_ch_last  (host_ch_last),
        .host_avg_log2 (host_avg_log2),
        .host_ack      (host_ack),
        .mon_en        (mon_en),
        .xadc_start    (xadc_start),
        .xadc_ch_sel   (xadc_ch_sel),
        .xadc_done     (xadc_done),
        .xadc_result   (xadc_result),
        .xadc_rst      (xadc_rst),
        .res_valid     (res_valid),
        .res_ch        (res_ch),
        .res_data      (res_data),
        .res_src       (res_src),
        .res_last      (res_last),
        .res_err       (res_err),
        .busy          (busy)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected results for one scan, derived from range/averaging rules.
    task automatic plan_scan(input logic [4:0] first, input logic [4:0] last, input int avg,
                             input int pat, input bit hang, input logic [4:0] hch, input logic src);
        int n;
        int ch;
        int sum;
        logic [11:0] v;
        n  = 1 << ((avg > MAX_AVG) ? MAX_AVG : avg);
        ch = int'(first);
        for (int g = 0; g < 32; g++) begin
            if (hang && ch == int'(hch)) begin
                start_q.push_back(5'(ch));
                exp_q.push_back({src, (ch == int'(last)), 1'b1, 5'(ch), 12'd0});
            end else begin
                sum = 0;
                for (int k = 0; k < n; k++) begin
                    if (pat == 1) v = (k % 2 == 0) ? 12'd100 : 12'd102;
                    else if (pat == 2) v = 12'hFFF;
                    else v = 12'($urandom_range(0, 4095));
                    smp_q.push_back(v);
                    start_q.push_back(5'(ch));
                    sum += int'(v);
                end
                exp_q.push_back({src, (ch == int'(last)), 1'b0, 5'(ch), 12'(sum / n)});
            end
            if (ch == int'(last)) break;
            ch = (ch + 1) % 32;
        end
    endtask

    task automatic host_drive(input logic [4:0] f, input logic [4:0] l, input logic [2:0] a);
        host_ch_first = f;
        host_ch_last  = l;
        host_avg_log2 = a;
        host_req      = 1'b1;
    endtask

    task automatic host_wait_ack(input string nm);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk200);
            if (host_ack) begin
                got = 1'b1;
                break;
            end
        end
        check({nm, "_ack_seen"}, 32'(got), 32'd1);
        check({nm, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk200);
        #1 host_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk200);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_complete"}, 32'(ok), 32'd1);
        if (!ok) begin
            exp_q.delete();
            smp_q.delete();
            start_q.delete();
        end
        repeat (8) @(negedge clk200);
    endtask

    task automatic run_scan(input vec_t v, input string nm);
        ack_cnt  = 0;
        n_starts = 0;
        res_cnt  = 0;
        hang_en  = v.hang;
        hang_ch  = v.hang_ch;
        plan_scan(v.first, v.last, int'(v.avg), v.pat, v.hang, v.hang_ch, 1'b0);
        @(posedge clk200);
        #1 host_drive(v.first, v.last, v.avg);
        host_wait_ack(nm);
        wait_idle(nm, 20000);
        check({nm, "_nres"}, 32'(res_cnt), 32'(v.exp_nres));
        check({nm, "_starts"}, 32'(n_starts), 32'(v.exp_starts));
        check({nm, "_acks"}, 32'(ack_cnt), 32'd1);
    endtask

    // Read engine model: answers each start after a random delay unless hung.
    initial begin
        xadc_done   = 1'b0;
        xadc_result = '0;
        forever begin
            @(posedge clk200);
            if (xadc_start === 1'b1) begin
                n_starts++;
                if (start_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_unexpected actual_ch=%0h expected=none", xadc_ch_sel);
                end else begin
                    check("start_ch", 32'(xadc_ch_sel), 32'(start_q.pop_front()));
                end
                if (!(hang_en && xadc_ch_sel == hang_ch)) begin
                    repeat ($urandom_range(1, 6)) @(posedge clk200);
                    #1;
                    xadc_done   = 1'b1;
                    xadc_result = (smp_q.size() > 0) ? smp_q.pop_front() : 12'h000;
                    @(posedge clk200);
                    #1 xadc_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard and reset-pulse length monitor.
    always @(negedge clk200) begin
        if (host_ack) ack_cnt++;
        if (res_valid) begin
            res_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL result_unexpected actual=%0h expected=none",
                         {res_src, res_last, res_err, res_ch, res_data});
            end else begin
                check("result", 32'({res_src, res_last, res_err, res_ch, res_data}), 32'(exp_q.pop_front()));
            end
        end
        if (xadc_rst) begin
            rlen++;
        end else if (rlen != 0) begin
            check("xadc_rst_len", 32'(rlen), 32'd4);
            rlen = 0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   len;
        int   n;
        int   s0;
        bit   started;

        rst           = 1'b1;
        host_req      = 1'b0;
        host_ch_first = '0;
        host_ch_last  = '0;
        host_avg_log2 = '0;
        mon_en        = 1'b0;

        tbl[0] = '{5'h00, 5'h02, 3'd1, 1, 1'b0, 5'h00, 3, 6};
        tbl[1] = '{5'h1E, 5'h01, 3'd0, 0, 1'b0, 5'h00, 4, 4};
        tbl[2] = '{5'h00, 5'h05, 3'd1, 0, 1'b1, 5'h03, 6, 11};
        tbl[3] = '{5'h05, 5'h05, 3'd7, 2, 1'b0, 5'h00, 1, 16};
        tbl[4] = '{5'h0A, 5'h0C, 3'd3, 0, 1'b0, 5'h00, 3, 24};
        tbl[5] = '{5'h07, 5'h07, 3'd0, 0, 1'b0, 5'h00, 1, 1};

        repeat (3) @(negedge clk200);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(xadc_start), 32'd0);
        check("rst_xrst", 32'(xadc_rst), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        @(posedge clk200);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk200);

        for (int i = 0; i < 6; i++) begin
            run_scan(tbl[i], $sformatf("vec%0d", i));
        end

        // Host and monitor requests land in the same cycle; host goes first.
        ack_cnt  = 0;
        n_starts = 0;
        res_cnt  = 0;
        hang_en  = 1'b0;
        plan_scan(5'h00, 5'h01, 0, 0, 1'b0, 5'h00, 1'b0);
        plan_scan(5'h10, 5'h17, 2, 0, 1'b0, 5'h00, 1'b1);
        @(posedge clk200);
        #1 mon_en = 1'b1;
        repeat (MON_P) @(posedge clk200);
        #1;
        host_drive(5'h00, 5'h01, 3'd0);
        mon_en = 1'b0;
        host_wait_ack("prio");
        wait_idle("prio", 20000);
        check("prio_nres", 32'(res_cnt), 32'd10);
        check("prio_starts", 32'(n_starts), 32'd34);
        check("prio_acks", 32'(ack_cnt), 32'd1);

        // Reset while the engine is stuck in a read.
        hang_en = 1'b1;
        hang_ch = 5'h03;
        start_q.push_back(5'h03);
        @(posedge clk200);
        #1 host_drive(5'h03, 5'h04, 3'd0);
        host_wait_ack("rstmid");
        s0      = n_starts;
        started = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk200);
            if (n_starts > s0) begin
                started = 1'b1;
                break;
            end
        end
        check("rstmid_started", 32'(started), 32'd1);
        repeat (3) @(posedge clk200);
        #2 rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_chsel", 32'(xadc_ch_sel), 32'd0);
        check("rstmid_start", 32'(xadc_start), 32'd0);
        check("rstmid_valid", 32'(res_valid), 32'd0);
        repeat (3) @(posedge clk200);
        exp_q.delete();
        smp_q.delete();
        start_q.delete();
        #1 rst = 1'b0;
        hang_en = 1'b0;
        repeat (5) @(negedge clk200);
        run_scan(tbl[5], "after_rst");

        for (int r = 0; r < 6; r++) begin
            v.first   = 5'($urandom_range(0, 31));
            len       = int'($urandom_range(1, 4));
            v.last    = 5'((int'(v.first) + len - 1) % 32);
            v.avg     = 3'($urandom_range(0, 7));
            v.pat     = 0;
            v.hang    = ($urandom_range(0, 3) == 0);
            v.hang_ch = 5'((int'(v.first) + int'($urandom_range(0, len - 1))) % 32);
            n         = 1 << ((v.avg > 3'd4) ? 4 : int'(v.avg));
            v.exp_nres   = len;
            v.exp_starts = v.hang ? (len - 1) * n + 1 : len * n;
            run_scan(v, $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
